// File: rtl/key_event_decoder.sv
// Turns the key detector's 2-bit event strobe into single, double and hold pulses.
// It also keeps a wrapping count of the events it has emitted.
module key_event_decoder #(
  parameter int unsigned GAP_CYCLES = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] key_code,
  output logic       single_pulse,
  output logic       double_pulse,
  output logic       hold_pulse,
  output logic       code_error,
  output logic       busy,
  output logic [7:0] event_count
);

  localparam logic [15:0] GAP_LOAD = 16'(GAP_CYCLES);

  localparam logic [1:0] CODE_PRESS   = 2'b01;
  localparam logic [1:0] CODE_HOLD    = 2'b11;
  localparam logic [1:0] CODE_ILLEGAL = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01
  } state_t;

  state_t      state, state_next;
  logic [15:0] gap_timer, gap_timer_next;
  logic        single_next, double_next, hold_next, error_next;
  logic [7:0]  event_count_next;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      gap_timer    <= '0;
      single_pulse <= 1'b0;
      double_pulse <= 1'b0;
      hold_pulse   <= 1'b0;
      code_error   <= 1'b0;
      busy         <= 1'b0;
      event_count  <= '0;
    end else begin
      state        <= state_next;
      gap_timer    <= gap_timer_next;
      single_pulse <= single_next;
      double_pulse <= double_next;
      hold_pulse   <= hold_next;
      code_error   <= error_next;
      busy         <= (state_next == WAIT);
      event_count  <= event_count_next;
    end
  end

  always_comb begin
    state_next     = state;
    gap_timer_next = gap_timer;
    single_next    = 1'b0;
    double_next    = 1'b0;
    hold_next      = 1'b0;
    error_next     = (key_code == CODE_ILLEGAL);

    case (state)
      IDLE: begin
        if (key_code == CODE_PRESS) begin
          gap_timer_next = GAP_LOAD;
          state_next     = WAIT;
        end else if (key_code == CODE_HOLD) begin
          hold_next = 1'b1;
        end
      end
      WAIT: begin
        // An illegal code falls through to the timing branches like an idle cycle.
        if (key_code == CODE_PRESS) begin
          double_next    = 1'b1;
          gap_timer_next = '0;
          state_next     = IDLE;
        end else if (key_code == CODE_HOLD) begin
          single_next    = 1'b1;
          hold_next      = 1'b1;
          gap_timer_next = '0;
          state_next     = IDLE;
        end else if (gap_timer == 16'd1) begin
          single_next    = 1'b1;
          gap_timer_next = '0;
          state_next     = IDLE;
        end else begin
          gap_timer_next = gap_timer - 16'd1;
        end
      end
      default: begin
        state_next     = IDLE;
        gap_timer_next = '0;
      end
    endcase

    event_count_next = event_count + {7'd0, single_next} + {7'd0, double_next}
                     + {7'd0, hold_next};
  end

endmodule
